// File: rtl/rx_symbol_aligner.sv
// -----------------------------------------------------------------------------
// rx_symbol_aligner
//
// Per-lane receive comma aligner placed between the deserializer and the
// 8b/10b decoder. It looks for the K28.5 comma in a 20-bit sliding window made
// of the previous and current raw words. It acquires symbol lock after
// LOCK_CNT consecutive commas at the same bit offset, and it drops lock after
// UNLOCK_CNT consecutive commas at a foreign offset or on electrical idle.
// While locked it emits correctly framed 10-bit symbols, one cycle after the
// raw word arrives.
//
// Ports
//   clk           PIPE clock; all logic on the rising edge
//   reset_n       synchronous active-low reset
//   rxelecidle    lane electrical idle; forces unlock and overrides in_valid
//   in_valid      in_data carries a new raw word this cycle
//   in_data       raw deserialized word, bit 9 received first
//   out_valid     out_data holds an aligned symbol
//   out_data      aligned symbol, bit 9 = bit a (first on the wire)
//   out_is_comma  upper 7 bits of out_data match a comma pattern
//   locked        symbol lock achieved
//   align_offset  bit offset currently in use (0..9)
//   realign       one-cycle pulse when a new offset is captured
// -----------------------------------------------------------------------------
module rx_symbol_aligner #(
    parameter int LOCK_CNT   = 3,
    parameter int UNLOCK_CNT = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rxelecidle,
    input  logic       in_valid,
    input  logic [9:0] in_data,
    output logic       out_valid,
    output logic [9:0] out_data,
    output logic       out_is_comma,
    output logic       locked,
    output logic [3:0] align_offset,
    output logic       realign
);

    typedef enum logic [1:0] {
        UNLOCKED,
        CHECKING,
        LOCKED
    } state_t;

    localparam logic [3:0] LOCK_TGT   = 4'(LOCK_CNT);
    localparam logic [3:0] UNLOCK_TGT = 4'(UNLOCK_CNT);

    state_t      state, next_state;
    logic [9:0]  prev_word;
    logic        prev_loaded;
    logic [3:0]  offset, next_offset;
    logic [3:0]  cnt, next_cnt, cnt_inc;
    logic [3:0]  miss, next_miss, miss_inc;
    logic        next_realign;
    logic [19:0] window;
    logic        hit;
    logic [3:0]  hit_k;
    logic        evaluate;
    logic        emit;
    logic [9:0]  next_slice;

    function automatic logic is_comma7(input logic [6:0] upper);
        return (upper == 7'b0011111) || (upper == 7'b1100000);
    endfunction

    // prev_word is the older half, so candidate k starts k bits into it.
    assign window   = {prev_word, in_data};
    // The very first word after reset or idle only primes prev_word.
    assign evaluate = in_valid & prev_loaded & ~rxelecidle;

    // Counters saturate rather than wrap.
    assign cnt_inc  = (cnt  == 4'hF) ? cnt  : cnt  + 4'd1;
    assign miss_inc = (miss == 4'hF) ? miss : miss + 4'd1;

    // Scan from high k down so the lowest matching offset is the one kept.
    always_comb begin : comma_search
        hit   = 1'b0;
        hit_k = '0;
        for (int k = 9; k >= 0; k--) begin
            if (is_comma7(window[19-k -: 7])) begin
                hit   = 1'b1;
                hit_k = 4'(k);
            end
        end
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the block leaves a value unassigned and no latch is inferred.
    always_comb begin : next_state_logic
        next_state   = state;
        next_offset  = offset;
        next_cnt     = cnt;
        next_miss    = miss;
        next_realign = 1'b0;
        if (rxelecidle) begin
            next_state = UNLOCKED;
            next_cnt   = '0;
            next_miss  = '0;
        end else if (evaluate && hit) begin
            unique case (state)
                UNLOCKED: begin
                    next_offset  = hit_k;
                    next_cnt     = 4'd1;
                    next_realign = 1'b1;
                    if (LOCK_TGT == 4'd1) begin
                        next_state = LOCKED;
                        next_miss  = '0;
                    end else begin
                        next_state = CHECKING;
                    end
                end
                CHECKING: begin
                    if (hit_k == offset) begin
                        next_cnt = cnt_inc;
                        if (cnt_inc == LOCK_TGT) begin
                            next_state = LOCKED;
                            next_miss  = '0;
                        end
                    end else begin
                        next_offset  = hit_k;
                        next_cnt     = 4'd1;
                        next_realign = 1'b1;
                    end
                end
                LOCKED: begin
                    if (hit_k == offset) begin
                        next_miss = '0;
                    end else begin
                        next_miss = miss_inc;
                        if (miss_inc == UNLOCK_TGT) begin
                            next_state = UNLOCKED;
                            next_cnt   = '0;
                            next_miss  = '0;
                        end
                    end
                end
                default: next_state = UNLOCKED;
            endcase
        end
    end

    // The slice is taken at the offset being adopted this cycle, so the comma
    // that completes lock is itself framed and emitted.
    assign next_slice = window[5'd19 - {1'b0, next_offset} -: 10];
    // A word that causes unlock leaves next_state != LOCKED and is dropped.
    assign emit       = evaluate && (next_state == LOCKED);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= UNLOCKED;
            prev_word    <= '0;
            prev_loaded  <= 1'b0;
            offset       <= '0;
            cnt          <= '0;
            miss         <= '0;
            realign      <= 1'b0;
            locked       <= 1'b0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_is_comma <= 1'b0;
        end else begin
            state     <= next_state;
            offset    <= next_offset;
            cnt       <= next_cnt;
            miss      <= next_miss;
            realign   <= next_realign;
            locked    <= (next_state == LOCKED);
            out_valid <= emit;
            if (rxelecidle) begin
                prev_loaded <= 1'b0;
            end else if (in_valid) begin
                prev_word   <= in_data;
                prev_loaded <= 1'b1;
            end
            // Data outputs hold their last symbol while out_valid is low.
            if (emit) begin
                out_data     <= next_slice;
                out_is_comma <= is_comma7(next_slice[9:3]);
            end
        end
    end

    assign align_offset = offset;

endmodule

// File: tb/tb_rx_symbol_aligner.sv
// -----------------------------------------------------------------------------
// tb_rx_symbol_aligner
//
// Self-checking bench for rx_symbol_aligner. Raw words are cut from a bit
// stream built from symbols and filler bits, so every comma has a known start
// position. A behavioural model works from those known positions and pushes
// the expected outputs into a scoreboard queue, which is popped after each
// clock edge. A hand-written vector table covers the word-aligned case, and
// directed checks pin the key lock, unlock, idle and reset points.
// -----------------------------------------------------------------------------
module tb_rx_symbol_aligner;

    localparam int LOCK_CNT   = 3;
    localparam int UNLOCK_CNT = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       rxelecidle;
    logic       in_valid;
    logic [9:0] in_data;
    logic       out_valid;
    logic [9:0] out_data;
    logic       out_is_comma;
    logic       locked;
    logic [3:0] align_offset;
    logic       realign;

    always #5 clk = ~clk;

    rx_symbol_aligner #(.LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .rxelecidle   (rxelecidle),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_is_comma (out_is_comma),
        .locked       (locked),
        .align_offset (align_offset),
        .realign      (realign)
    );

    typedef struct {
        logic       ov;
        logic [9:0] od;
        logic       comma;
        logic       lock;
        logic [3:0] off;
        logic       re;
    } exp_t;

    typedef struct {
        logic       v;
        logic [9:0] d;
        exp_t       e;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    // Bit stream: one entry per wire bit, plus a flag marking comma starts.
    bit s_bits[$];
    bit s_cst[$];
    int wp;

    // Reference model state (0 unlocked, 1 checking, 2 locked).
    int   m_state, m_off, m_cnt, m_miss;
    bit   m_loaded;
    exp_t m_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add_sym(input logic [9:0] s);
        for (int i = 9; i >= 0; i--) begin
            s_bits.push_back(s[i]);
            s_cst.push_back((i == 9) && (s == 10'h0FA || s == 10'h305));
        end
    endtask

    // Alternating filler never forms a run of five, so no false commas.
    task automatic add_fill(input int n);
        bit b;
        b = (s_bits.size() == 0) ? 1'b0 : ~s_bits[$];
        for (int i = 0; i < n; i++) begin
            s_bits.push_back(b);
            s_cst.push_back(1'b0);
            b = ~b;
        end
    endtask

    task automatic add_pairs(input int n);
        for (int i = 0; i < n; i++) begin
            add_sym(10'h0FA);
            add_sym(10'h155);
        end
    endtask

    function automatic logic [9:0] word_at(input int n);
        logic [9:0] w;
        for (int i = 0; i < 10; i++) w[9-i] = s_bits[10*n + i];
        return w;
    endfunction

    function automatic bit word_avail();
        return (wp + 1) * 10 <= s_bits.size();
    endfunction

    task automatic model_reset();
        m_state  = 0;
        m_off    = 0;
        m_cnt    = 0;
        m_miss   = 0;
        m_loaded = 1'b0;
        m_e      = '{ov: 1'b0, od: 10'h000, comma: 1'b0, lock: 1'b0, off: 4'h0, re: 1'b0};
    endtask

    task automatic model_step(input bit v, input bit idle, input int n);
        int base;
        int k;
        m_e.re = 1'b0;
        if (idle) begin
            m_state  = 0;
            m_cnt    = 0;
            m_miss   = 0;
            m_loaded = 1'b0;
            m_e.ov   = 1'b0;
        end else if (!v) begin
            m_e.ov = 1'b0;
        end else if (!m_loaded) begin
            m_loaded = 1'b1;
            m_e.ov   = 1'b0;
        end else begin
            base = 10 * (n - 1);
            k    = -1;
            for (int j = 9; j >= 0; j--) if (s_cst[base + j]) k = j;
            if (k >= 0) begin
                if (m_state == 0) begin
                    m_off   = k;
                    m_cnt   = 1;
                    m_e.re  = 1'b1;
                    m_miss  = 0;
                    m_state = (LOCK_CNT == 1) ? 2 : 1;
                end else if (m_state == 1) begin
                    if (k == m_off) begin
                        if (m_cnt < 15) m_cnt++;
                        if (m_cnt == LOCK_CNT) begin
                            m_state = 2;
                            m_miss  = 0;
                        end
                    end else begin
                        m_off  = k;
                        m_cnt  = 1;
                        m_e.re = 1'b1;
                    end
                end else begin
                    if (k == m_off) begin
                        m_miss = 0;
                    end else begin
                        if (m_miss < 15) m_miss++;
                        if (m_miss == UNLOCK_CNT) begin
                            m_state = 0;
                            m_cnt   = 0;
                            m_miss  = 0;
                        end
                    end
                end
            end
            m_e.ov = (m_state == 2);
            if (m_e.ov) begin
                for (int i = 0; i < 10; i++) m_e.od[9-i] = s_bits[base + m_off + i];
                m_e.comma = s_cst[base + m_off];
            end
        end
        m_e.lock = (m_state == 2);
        m_e.off  = 4'(m_off);
        sb_q.push_back(m_e);
    endtask

    task automatic compare_pop();
        exp_t e;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: got no expectation, required one");
            return;
        end
        e = sb_q.pop_front();
        check("out_valid", out_valid, e.ov);
        check("out_data", out_data, e.od);
        check("out_is_comma", out_is_comma, e.comma);
        check("locked", locked, e.lock);
        check("align_offset", align_offset, e.off);
        check("realign", realign, e.re);
    endtask

    task automatic drive(input bit rst, input bit idle, input bit v, input logic [9:0] d);
        @(negedge clk);
        reset_n    = ~rst;
        rxelecidle = idle;
        in_valid   = v;
        in_data    = d;
        @(posedge clk);
        #1;
        compare_pop();
    endtask

    task automatic do_reset();
        model_reset();
        sb_q.push_back(m_e);
        drive(1'b1, 1'b0, 1'b0, 10'h000);
        s_bits.delete();
        s_cst.delete();
        wp = 0;
    endtask

    // One cycle from the stream; idle cycles consume (and lose) a word too.
    task automatic stream_cycle(input bit v, input bit idle);
        logic [9:0] d;
        int         n;
        n = -1;
        d = 10'($urandom);
        if (v) begin
            n = wp;
            d = word_at(wp);
            wp++;
        end
        model_step(v, idle, n);
        drive(1'b0, idle, v, d);
    endtask

    function automatic vec_t mk(input logic v, input logic [9:0] d, input logic ov,
                                input logic [9:0] od, input logic c, input logic lk,
                                input logic [3:0] off, input logic re);
        vec_t t;
        t.v = v;
        t.d = d;
        t.e = '{ov: ov, od: od, comma: c, lock: lk, off: off, re: re};
        return t;
    endfunction

    vec_t tbl[10];

    initial begin
        reset_n    = 1'b0;
        rxelecidle = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        wp         = 0;

        // Word-aligned stream: every window has the comma at k=0 in prev_word.
        tbl[0] = mk(1, 10'h0FA, 0, 10'h000, 0, 0, 4'd0, 0);
        tbl[1] = mk(1, 10'h305, 0, 10'h000, 0, 0, 4'd0, 1);
        tbl[2] = mk(1, 10'h0FA, 0, 10'h000, 0, 0, 4'd0, 0);
        tbl[3] = mk(1, 10'h305, 1, 10'h0FA, 1, 1, 4'd0, 0);
        tbl[4] = mk(1, 10'h0FA, 1, 10'h305, 1, 1, 4'd0, 0);
        tbl[5] = mk(0, 10'h123, 0, 10'h305, 1, 1, 4'd0, 0);
        tbl[6] = mk(1, 10'h305, 1, 10'h0FA, 1, 1, 4'd0, 0);
        tbl[7] = mk(1, 10'h0FA, 1, 10'h305, 1, 1, 4'd0, 0);
        tbl[8] = mk(1, 10'h155, 1, 10'h0FA, 1, 1, 4'd0, 0);
        tbl[9] = mk(1, 10'h155, 1, 10'h155, 0, 1, 4'd0, 0);

        // Reset state.
        do_reset();
        check("rst_out_valid", out_valid, 0);
        check("rst_locked", locked, 0);

        // Stream shifted by 3 bits: commas detected at words 1, 3, 5.
        add_fill(3);
        add_pairs(12);
        for (int i = 0; i < 24; i++) begin
            stream_cycle(1'b1, 1'b0);
            if (i == 1) begin
                check("t1_realign", realign, 1);
                check("t1_offset", align_offset, 3);
            end
            if (i == 4) check("t1_not_yet_locked", locked, 0);
            if (i == 5) begin
                check("t1_locked", locked, 1);
                check("t1_first_valid", out_valid, 1);
                check("t1_first_data", out_data, 10'h0FA);
                check("t1_first_comma", out_is_comma, 1);
            end
            if (i == 6) check("t1_data_d102", out_data, 10'h155);
        end

        // Foreign commas at offset 7: three then a good one keeps lock, then
        // four in a row drop it and the next comma realigns to 7.
        add_fill(4);
        add_pairs(3);
        add_fill(6);
        add_pairs(1);
        add_fill(4);
        add_pairs(7);
        add_fill(3);
        while (word_avail()) begin
            stream_cycle(1'b1, 1'b0);
            case (wp - 1)
                32: check("t3_still_locked", locked, 1);
                39: check("t3_locked_before_4th", locked, 1);
                40: begin
                    check("t3_unlocked", locked, 0);
                    check("t3_unlock_no_out", out_valid, 0);
                end
                42: begin
                    check("t3_realign", realign, 1);
                    check("t3_offset7", align_offset, 7);
                end
                46: begin
                    check("t3_relocked", locked, 1);
                    check("t3_relock_data", out_data, 10'h0FA);
                end
                default: ;
            endcase
        end

        // Hand-written word-aligned vectors.
        do_reset();
        foreach (tbl[i]) begin
            sb_q.push_back(tbl[i].e);
            drive(1'b0, 1'b0, tbl[i].v, tbl[i].d);
        end

        // Checking at offset 3 with cnt=2, then a comma at offset 5.
        do_reset();
        add_fill(3);
        add_pairs(2);
        add_fill(2);
        add_pairs(5);
        while (word_avail()) begin
            stream_cycle(1'b1, 1'b0);
            case (wp - 1)
                3: check("t4_checking_at_3", align_offset, 3);
                5: begin
                    check("t4_realign", realign, 1);
                    check("t4_offset5", align_offset, 5);
                    check("t4_not_locked", locked, 0);
                end
                7: check("t4_still_checking", locked, 0);
                9: begin
                    check("t4_locked", locked, 1);
                    check("t4_lock_data", out_data, 10'h0FA);
                end
                default: ;
            endcase
        end

        // Electrical idle while locked (with in_valid high), then relock.
        add_pairs(5);
        stream_cycle(1'b1, 1'b0);
        check("t5_locked_before_idle", locked, 1);
        stream_cycle(1'b1, 1'b1);
        check("t5_idle_locked", locked, 0);
        check("t5_idle_out_valid", out_valid, 0);
        check("t5_idle_offset_holds", align_offset, 5);
        while (word_avail()) begin
            stream_cycle(1'b1, 1'b0);
            case (wp - 1)
                16: begin
                    check("t5_prime_no_detect", realign, 0);
                    check("t5_prime_unlocked", locked, 0);
                end
                19: check("t5_two_commas", locked, 0);
                21: check("t5_relocked", locked, 1);
                default: ;
            endcase
        end

        // in_valid every other cycle: lock lands on the same valid word.
        do_reset();
        add_fill(3);
        add_pairs(8);
        for (int i = 0; i < 10; i++) begin
            stream_cycle(1'b1, 1'b0);
            if (i == 4) check("t6_not_locked", locked, 0);
            if (i == 5) check("t6_locked", locked, 1);
            stream_cycle(1'b0, 1'b0);
            if (i == 5) check("t6_gap_out_valid", out_valid, 0);
        end
        check("t6_locked_before_reset", locked, 1);
        do_reset();
        check("t6_rst_out_valid", out_valid, 0);
        check("t6_rst_out_data", out_data, 0);
        check("t6_rst_comma", out_is_comma, 0);
        check("t6_rst_locked", locked, 0);
        check("t6_rst_offset", align_offset, 0);
        check("t6_rst_realign", realign, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
